// File: rtl/cache_miss_ctrl.sv
// Miss handler: picks a victim way, optionally writes back a dirty victim,
// fills the line over a req/ack memory port and strobes the metadata store.
module cache_miss_ctrl #(
  parameter int TAG_W = 8,
  parameter int NWAYS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [NWAYS-1:0]       req_hit,
  input  logic [1:0]             req_index,
  input  logic [TAG_W-1:0]       req_tag,
  output logic                   req_ready,
  input  logic [NWAYS-1:0]       VALID_in,
  input  logic [NWAYS-1:0]       DIRTY_in,
  input  logic [NWAYS-1:0]       PTC_in,
  input  logic [4*NWAYS-1:0]     LRU_in,
  input  logic [NWAYS*TAG_W-1:0] vtag_in,
  output logic [1:0]             meta_index,
  output logic [NWAYS-1:0]       meta_way,
  output logic                   meta_valid,
  output logic                   meta_wb,
  output logic                   meta_ex,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [TAG_W+1:0]       mem_addr,
  input  logic                   mem_ack,
  output logic                   done,
  output logic [NWAYS-1:0]       done_way
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_VICTIM  = 3'd1;
  localparam logic [2:0] S_WB      = 3'd2;
  localparam logic [2:0] S_WB_DONE = 3'd3;
  localparam logic [2:0] S_FILL    = 3'd4;
  localparam logic [2:0] S_INSTALL = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [1:0]       index_q, index_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] vtag_q, vtag_d;
  logic [NWAYS-1:0] way_q, way_d;

  logic             inv_found;
  logic [1:0]       inv_idx;
  logic             lru_found;
  logic [1:0]       lru_idx;
  logic [3:0]       lru_best;
  logic             victim_ok;
  logic [1:0]       victim_idx;
  logic             victim_dirty;
  logic [TAG_W-1:0] victim_tag;

  // Invalid ways win outright; otherwise oldest non-pending way, lowest index on ties.
  always_comb begin
    inv_found = 1'b0;
    inv_idx   = 2'd0;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (!VALID_in[w]) begin
        inv_found = 1'b1;
        inv_idx   = 2'(w);
      end
    end
    lru_found = 1'b0;
    lru_idx   = 2'd0;
    lru_best  = 4'd0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!PTC_in[w] && (!lru_found || (LRU_in[4*w +: 4] > lru_best))) begin
        lru_found = 1'b1;
        lru_idx   = 2'(w);
        lru_best  = LRU_in[4*w +: 4];
      end
    end
    victim_ok    = inv_found || lru_found;
    victim_idx   = inv_found ? inv_idx : lru_idx;
    victim_dirty = VALID_in[victim_idx] && DIRTY_in[victim_idx];
    victim_tag   = vtag_in[victim_idx*TAG_W +: TAG_W];
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    tag_d   = tag_q;
    vtag_d  = vtag_q;
    way_d   = way_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && (req_hit == '0)) begin
          index_d = req_index;
          tag_d   = req_tag;
          state_d = S_VICTIM;
        end
      end
      S_VICTIM: begin
        if (victim_ok) begin
          way_d = NWAYS'(1) << victim_idx;
          if (victim_dirty) begin
            vtag_d  = victim_tag;
            state_d = S_WB;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_WB:      if (mem_ack) state_d = S_WB_DONE;
      S_WB_DONE: state_d = S_FILL;
      S_FILL:    if (mem_ack) state_d = S_INSTALL;
      S_INSTALL: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      index_q <= '0;
      tag_q   <= '0;
      vtag_q  <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      tag_q   <= tag_d;
      vtag_q  <= vtag_d;
      way_q   <= way_d;
    end
  end

  // Outputs decode from state so a reset kills mem_req and strobes instantly.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    mem_req    = (state_q == S_WB) || (state_q == S_FILL);
    mem_we     = (state_q == S_WB);
    meta_valid = (state_q == S_WB_DONE) || (state_q == S_INSTALL);
    meta_wb    = (state_q == S_WB_DONE);
    meta_ex    = (state_q == S_INSTALL);
    done       = (state_q == S_INSTALL);
    done_way   = (state_q == S_INSTALL) ? way_q : '0;
    meta_index = index_q;
    meta_way   = way_q;
    mem_addr   = '0;
    if (state_q == S_WB)   mem_addr = {vtag_q, index_q};
    if (state_q == S_FILL) mem_addr = {tag_q, index_q};
  end

endmodule
